// File: rtl/fb_scan_reader_if.sv
// rtl/fb_scan_reader_if.sv - timing, swap handshake, BRAM read and pixel bus for the scan reader
interface fb_scan_reader_if #(
    parameter int AW = 17
);
    logic [10:0]   hcount_in;
    logic [9:0]    vcount_in;
    logic          hs_in;
    logic          vs_in;
    logic          ad_in;
    logic          nf_in;
    logic          swap_req_in;
    logic          swap_ack_out;
    logic          front_buf_out;
    logic [AW-1:0] rd_addr_out;
    logic [15:0]   rd_data_in;
    logic [23:0]   pixel_out;
    logic          hs_out;
    logic          vs_out;
    logic          ad_out;

    // Scan reader side
    modport slave (
        input  hcount_in, vcount_in, hs_in, vs_in, ad_in, nf_in, swap_req_in, rd_data_in,
        output swap_ack_out, front_buf_out, rd_addr_out, pixel_out, hs_out, vs_out, ad_out
    );

    // Timing generator / renderer / BRAM side
    modport master (
        output hcount_in, vcount_in, hs_in, vs_in, ad_in, nf_in, swap_req_in, rd_data_in,
        input  swap_ack_out, front_buf_out, rd_addr_out, pixel_out, hs_out, vs_out, ad_out
    );
endinterface

// File: rtl/fb_scan_reader.sv
// rtl/fb_scan_reader.sv - double-buffered framebuffer scan-out with integer upscale and RGB565 expansion
module fb_scan_reader #(
    parameter int H_ACTIVE     = 1280,
    parameter int V_ACTIVE     = 720,
    parameter int SCALE_SHIFT  = 2,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk_pixel_in,
    input  logic              rst_n_in,
    fb_scan_reader_if.slave   bus
);
    localparam int FB_W     = H_ACTIVE >> SCALE_SHIFT;
    localparam int FB_H     = V_ACTIVE >> SCALE_SHIFT;
    localparam int FB_WORDS = FB_W * FB_H;
    localparam int AW       = $clog2(2 * FB_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_ACK,
        S_WAIT_LOW
    } swap_state_t;

    swap_state_t r_state;
    logic        r_front_buf;
    logic        r_swap_ack;

    logic [AW-1:0]                 r_rd_addr;
    logic [READ_LATENCY:0][2:0]    r_ctl;      // {hs, vs, ad} per stage
    logic [23:0]                   r_pixel;
    logic                          r_hs_out;
    logic                          r_vs_out;
    logic                          r_ad_out;

    logic [AW-1:0] w_row;
    logic [AW-1:0] w_col;
    logic [AW-1:0] w_base;
    logic [AW-1:0] w_addr;
    logic [2:0]    w_ctl_aligned;
    logic [15:0]   w_rgb565;

    // Full-width address: buffer base plus downscaled row/column offset
    assign w_row  = AW'(bus.vcount_in >> SCALE_SHIFT);
    assign w_col  = AW'(bus.hcount_in >> SCALE_SHIFT);
    assign w_base = r_front_buf ? AW'(FB_WORDS) : '0;
    assign w_addr = bus.ad_in ? (w_base + w_row * AW'(FB_W) + w_col) : w_base;

    assign w_ctl_aligned = r_ctl[READ_LATENCY];
    assign w_rgb565      = bus.rd_data_in;

    // Stage 0: register the read address and the sync/active sideband
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_rd_addr <= '0;
            r_ctl[0]  <= '0;
        end else begin
            r_rd_addr <= w_addr;
            r_ctl[0]  <= {bus.hs_in, bus.vs_in, bus.ad_in};
        end
    end

    // Stages 1..READ_LATENCY: delay sideband to line up with BRAM data
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 1; i <= READ_LATENCY; i++) r_ctl[i] <= '0;
        end else begin
            for (int i = 1; i <= READ_LATENCY; i++) r_ctl[i] <= r_ctl[i-1];
        end
    end

    // Final stage: expand RGB565 by replicating high bits, blank outside active video
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pixel  <= '0;
            r_hs_out <= 1'b0;
            r_vs_out <= 1'b0;
            r_ad_out <= 1'b0;
        end else begin
            {r_hs_out, r_vs_out, r_ad_out} <= w_ctl_aligned;
            if (w_ctl_aligned[0]) begin
                r_pixel <= {w_rgb565[15:11], w_rgb565[15:13],
                            w_rgb565[10:5],  w_rgb565[10:9],
                            w_rgb565[4:0],   w_rgb565[4:2]};
            end else begin
                r_pixel <= '0;
            end
        end
    end

    // Swap FSM: buffers only exchange on a new-frame pulse, one swap per request
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state     <= S_IDLE;
            r_front_buf <= 1'b0;
            r_swap_ack  <= 1'b0;
        end else begin
            r_swap_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.swap_req_in) begin
                        if (bus.nf_in) begin
                            r_front_buf <= ~r_front_buf;
                            r_swap_ack  <= 1'b1;
                            r_state     <= S_ACK;
                        end else begin
                            r_state <= S_PENDING;
                        end
                    end
                end
                S_PENDING: begin
                    if (!bus.swap_req_in) begin
                        r_state <= S_IDLE;
                    end else if (bus.nf_in) begin
                        r_front_buf <= ~r_front_buf;
                        r_swap_ack  <= 1'b1;
                        r_state     <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_state <= bus.swap_req_in ? S_WAIT_LOW : S_IDLE;
                end
                S_WAIT_LOW: begin
                    if (!bus.swap_req_in) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rd_addr_out   = r_rd_addr;
    assign bus.pixel_out     = r_pixel;
    assign bus.hs_out        = r_hs_out;
    assign bus.vs_out        = r_vs_out;
    assign bus.ad_out        = r_ad_out;
    assign bus.swap_ack_out  = r_swap_ack;
    assign bus.front_buf_out = r_front_buf;
endmodule

// File: tb/tb_fb_scan_reader.sv
// tb/tb_fb_scan_reader.sv - self-checking bench for fb_scan_reader
module tb_fb_scan_reader;
    localparam int H_ACT    = 1280;
    localparam int V_ACT    = 720;
    localparam int SHIFT    = 2;
    localparam int RL       = 2;
    localparam int FBW      = H_ACT >> SHIFT;
    localparam int FBH      = V_ACT >> SHIFT;
    localparam int WORDS    = FBW * FBH;
    localparam int AW       = 17;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fb_scan_reader_if #(.AW(AW)) bus ();

    fb_scan_reader #(
        .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .SCALE_SHIFT(SHIFT), .READ_LATENCY(RL)
    ) dut (
        .clk_pixel_in(clk),
        .rst_n_in(rst_n),
        .bus(bus)
    );

    // BRAM model with RL cycles of read latency
    logic [15:0]   mem [0:2*WORDS-1];
    logic [AW-1:0] bram_pipe [RL] = '{default: '0};
    always @(posedge clk) begin
        bram_pipe[0] <= bus.rd_addr_out;
        for (int i = 1; i < RL; i++) bram_pipe[i] <= bram_pipe[i-1];
    end
    assign bus.rd_data_in = mem[bram_pipe[RL-1]];

    int n_vec = 0;
    int n_bad = 0;
    int ack_seen = 0;

    typedef struct { logic [23:0] pix; logic hs; logic vs; logic ad; } out_t;
    out_t hist[$];
    out_t exp_out;
    int   exp_addr;
    logic m_front, m_served, m_ack;

    typedef struct {
        logic [10:0] h; logic [9:0] v; logic hs; logic vs; logic ad;
        logic [15:0] data; int exp_addr; logic [23:0] exp_pix;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] rgb888(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]); g = int'(p[10:5]); b = int'(p[4:0]);
        return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
    endfunction

    task automatic drive(input int h, input int v, input logic hs, input logic vs,
                         input logic ad, input logic nf, input logic req);
        bus.hcount_in   = 11'(h);
        bus.vcount_in   = 10'(v);
        bus.hs_in       = hs;
        bus.vs_in       = vs;
        bus.ad_in       = ad;
        bus.nf_in       = nf;
        bus.swap_req_in = req;
    endtask

    task automatic model_reset();
        out_t z;
        z = '{pix: 24'h0, hs: 1'b0, vs: 1'b0, ad: 1'b0};
        hist.delete();
        for (int i = 0; i < RL + 1; i++) hist.push_back(z);
        m_front = 1'b0; m_served = 1'b0; m_ack = 1'b0;
    endtask

    // Reference: address from pixel coordinates, output equals the input record RL+2 edges back
    task automatic model_edge();
        out_t e;
        int base;
        base = m_front ? WORDS : 0;
        exp_addr = bus.ad_in ? base + (int'(bus.vcount_in) / (1 << SHIFT)) * FBW
                                    + int'(bus.hcount_in) / (1 << SHIFT)
                             : base;
        e.ad  = bus.ad_in;
        e.hs  = bus.hs_in;
        e.vs  = bus.vs_in;
        e.pix = bus.ad_in ? rgb888(mem[exp_addr]) : 24'h0;
        hist.push_back(e);
        exp_out = hist.pop_front();
        m_ack = 1'b0;
        if (bus.swap_req_in && bus.nf_in && !m_served) begin
            m_front  = ~m_front;
            m_served = 1'b1;
            m_ack    = 1'b1;
        end else if (!bus.swap_req_in) begin
            m_served = 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_edge();
        chk("rd_addr", 32'(bus.rd_addr_out), 32'(exp_addr));
        chk("pixel", 32'(bus.pixel_out), 32'(exp_out.pix));
        chk("hs_vs_ad", {29'b0, bus.hs_out, bus.vs_out, bus.ad_out}, {29'b0, exp_out.hs, exp_out.vs, exp_out.ad});
        chk("front_buf", 32'(bus.front_buf_out), 32'(m_front));
        chk("swap_ack", 32'(bus.swap_ack_out), 32'(m_ack));
        if (bus.swap_ack_out) ack_seen++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, 32'(bus.rd_addr_out), 32'h0);
        chk({tag, "_pix"}, 32'(bus.pixel_out), 32'h0);
        chk({tag, "_sync"}, {29'b0, bus.hs_out, bus.vs_out, bus.ad_out}, 32'h0);
        chk({tag, "_ack"}, 32'(bus.swap_ack_out), 32'h0);
        chk({tag, "_front"}, 32'(bus.front_buf_out), 32'h0);
    endtask

    initial begin
        int acks0;
        logic req;
        for (int i = 0; i < 2 * WORDS; i++) mem[i] = 16'($urandom);
        mem[0]     = 16'hFFFF;
        mem[57599] = 16'h07E0;
        mem[WORDS + 57599] = 16'h07E0;

        tbl[0] = '{h: 4,    v: 4,   hs: 0, vs: 0, ad: 1, data: 16'hF800, exp_addr: 321,   exp_pix: 24'hFF0000};
        tbl[1] = '{h: 0,    v: 0,   hs: 1, vs: 0, ad: 0, data: 16'h0000, exp_addr: 0,     exp_pix: 24'h000000};
        tbl[2] = '{h: 7,    v: 3,   hs: 0, vs: 1, ad: 1, data: 16'h001F, exp_addr: 1,     exp_pix: 24'h0000FF};
        tbl[3] = '{h: 639,  v: 359, hs: 0, vs: 0, ad: 1, data: 16'h8410, exp_addr: 28639, exp_pix: 24'h848284};
        tbl[4] = '{h: 1279, v: 0,   hs: 1, vs: 1, ad: 1, data: 16'hFFFF, exp_addr: 319,   exp_pix: 24'hFFFFFF};
        tbl[5] = '{h: 0,    v: 719, hs: 0, vs: 0, ad: 1, data: 16'h0000, exp_addr: 57280, exp_pix: 24'h000000};
        tbl[6] = '{h: 100,  v: 100, hs: 0, vs: 1, ad: 0, data: 16'h0000, exp_addr: 0,     exp_pix: 24'h000000};
        tbl[7] = '{h: 1279, v: 719, hs: 0, vs: 0, ad: 1, data: 16'h07E0, exp_addr: 57599, exp_pix: 24'h00FF00};
        foreach (tbl[i]) if (tbl[i].ad) mem[tbl[i].exp_addr] = tbl[i].data;

        // Reset state
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        model_reset();

        // Table-driven vectors: address one cycle later, pixel/sync four cycles after input
        for (int i = 0; i < 8 + RL + 1; i++) begin
            if (i < 8) drive(tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs, tbl[i].ad, 0, 0);
            else       drive(0, 0, 0, 0, 0, 0, 0);
            cycle();
            if (i < 8) chk("tbl_addr", 32'(bus.rd_addr_out), 32'(tbl[i].exp_addr));
            if (i >= RL + 1) begin
                chk("tbl_pix", 32'(bus.pixel_out), 32'(tbl[i-RL-1].exp_pix));
                chk("tbl_ad", 32'(bus.ad_out), 32'(tbl[i-RL-1].ad));
                chk("tbl_hs_vs", {30'b0, bus.hs_out, bus.vs_out}, {30'b0, tbl[i-RL-1].hs, tbl[i-RL-1].vs});
            end
        end

        // Request held across frames: one swap, one ack
        acks0 = ack_seen;
        for (int i = 0; i < 5; i++) begin drive(i * 37, 200, 0, 0, 1, 0, 1); cycle(); end
        chk("hold_front_before_nf", 32'(bus.front_buf_out), 32'h0);
        drive(0, 720, 0, 0, 0, 1, 1); cycle();
        chk("front_after_nf", 32'(bus.front_buf_out), 32'h1);
        for (int i = 0; i < 5; i++) begin drive(i * 11, 10, 0, 0, 1, 0, 1); cycle(); end
        drive(0, 720, 0, 0, 0, 1, 1); cycle();
        chk("no_second_swap", 32'(bus.front_buf_out), 32'h1);
        drive(0, 0, 0, 0, 0, 0, 0); cycle();
        chk("ack_count_held", 32'(ack_seen - acks0), 32'h1);

        // Back-buffer address corner
        drive(1279, 719, 0, 0, 1, 0, 0); cycle();
        chk("max_addr_front1", 32'(bus.rd_addr_out), 32'd115199);
        for (int i = 0; i < RL + 1; i++) begin drive(0, 0, 0, 0, 0, 0, 0); cycle(); end
        chk("max_pix_front1", 32'(bus.pixel_out), 32'h00FF00);

        // Request and new-frame in the same cycle, then a cancelled request
        drive(0, 720, 0, 0, 0, 1, 1); cycle();
        chk("same_cycle_front", 32'(bus.front_buf_out), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0); cycle();
        chk("same_cycle_ack_drop", 32'(bus.swap_ack_out), 32'h0);
        acks0 = ack_seen;
        for (int i = 0; i < 3; i++) begin drive(8, 8, 0, 0, 1, 0, 1); cycle(); end
        drive(8, 8, 0, 0, 1, 0, 0); cycle();
        drive(0, 720, 0, 0, 0, 1, 0); cycle();
        drive(0, 0, 0, 0, 0, 0, 0); cycle();
        chk("cancel_front", 32'(bus.front_buf_out), 32'h0);
        chk("cancel_ack_count", 32'(ack_seen - acks0), 32'h0);

        // Mid-line asynchronous reset with a swap pending
        drive(0, 720, 0, 0, 0, 1, 1); cycle();
        drive(0, 0, 0, 0, 0, 0, 0); cycle();
        for (int i = 0; i < 6; i++) begin drive(i * 100, 300, 1, 1, 1, 0, 1); cycle(); end
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 720, 0, 0, 0, 1, 0); cycle();
        chk("post_rst_front", 32'(bus.front_buf_out), 32'h0);

        // Randomized traffic against the reference model
        req = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) req = ~req;
            drive($urandom_range(0, H_ACT - 1), $urandom_range(0, V_ACT - 1),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0), req);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fb_scan_reader.md
FB_SCAN_READER -- requirements
Module: fb_scan_reader

Interface
REQ-001 Parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 720, active lines per frame.
REQ-003 Parameter SCALE_SHIFT, default 2, log2 upscale factor; buffer is FB_W=H_ACTIVE>>SCALE_SHIFT by FB_H=V_ACTIVE>>SCALE_SHIFT (320x180 default).
REQ-004 Parameter READ_LATENCY, default 2, BRAM read latency in cycles (1..4).
REQ-005 Derived: FB_WORDS=FB_W*FB_H; AW=$clog2(2*FB_WORDS) (17 default).
REQ-006 clk_pixel_in  input  1  pixel clock; single clock domain.
REQ-007 rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-008 hcount_in  input  11  horizontal position from timing generator.
REQ-009 vcount_in  input  10  vertical position from timing generator.
REQ-010 hs_in, vs_in, ad_in  input  1 each  hsync, vsync, active-display.
REQ-011 nf_in  input  1  new-frame pulse, one cycle, first blanking cycle after last active pixel.
REQ-012 swap_req_in  input  1  renderer request to exchange front/back buffers.
REQ-013 swap_ack_out  output  1  one-cycle acknowledge of completed swap.
REQ-014 front_buf_out  output  1  index (0/1) of buffer being scanned; renderer writes the other.
REQ-015 rd_addr_out  output  AW  BRAM read address.
REQ-016 rd_data_in  input  16  BRAM read data, RGB565, valid READ_LATENCY cycles after address.
REQ-017 pixel_out  output  24  RGB888 pixel {R,G,B}.
REQ-018 hs_out, vs_out, ad_out  output  1 each  sync/active delayed to align with pixel_out.

Function
REQ-019 Stage 0 (registered): rd_addr_out = front_buf*FB_WORDS + (vcount_in>>SCALE_SHIFT)*FB_W + (hcount_in>>SCALE_SHIFT) when ad_in=1; front_buf*FB_WORDS when ad_in=0.
REQ-020 Address arithmetic SHALL be computed at full AW width without truncation; multiply by FB_W is by constant.
REQ-021 Stages 1..READ_LATENCY: hs/vs/ad shift register matching BRAM latency.
REQ-022 Final stage (registered): RGB565 to RGB888 expansion R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
REQ-023 pixel_out SHALL be 24'h000000 whenever the aligned ad is 0.
REQ-024 Total latency input->outputs SHALL be READ_LATENCY+2 cycles (4 default) for pixel_out, hs_out, vs_out, ad_out identically.
REQ-025 Swap FSM states: IDLE, PENDING, ACK.
REQ-026 IDLE: swap_req_in=1 -> PENDING; if nf_in=1 in the same cycle, swap occurs immediately (toggle front_buf, -> ACK).
REQ-027 PENDING: on nf_in=1 toggle front_buf, -> ACK; otherwise hold.
REQ-028 ACK: swap_ack_out=1 for exactly one cycle, then -> WAIT_LOW-equivalent: remain out of IDLE until swap_req_in=0 (at most one swap per request).
REQ-029 front_buf SHALL never change except on an nf_in cycle, so no frame mixes buffers.
REQ-030 front_buf_out SHALL reflect the toggled value the cycle after the nf_in edge that swapped.
REQ-031 swap_req_in dropped while PENDING SHALL cancel the request (-> IDLE, no swap).

Reset
REQ-032 rst_n_in=0 SHALL asynchronously clear: pipeline registers, rd_addr_out=0, pixel_out=0, hs_out=vs_out=ad_out=0, swap_ack_out=0, front_buf_out=0, FSM=IDLE.
REQ-033 Release is synchronous to clk_pixel_in; outputs remain 0 until valid data propagates (READ_LATENCY+2 cycles).
REQ-034 Reset mid-frame SHALL discard any pending swap.

Verification
REQ-035 hcount=4,vcount=4,ad=1,front=0 -> rd_addr_out=321 next cycle; rd_data 16'hF800 -> pixel_out 24'hFF0000 4 cycles after input.
REQ-036 hcount=1279,vcount=719,front=1 -> rd_addr_out=57600+57599=115199.
REQ-037 ad_in toggling pattern 1,0,1 with hs/vs pulses -> identical pattern on ad_out/hs_out/vs_out 4 cycles later; pixel_out=0 on ad_out=0 cycle.
REQ-038 swap_req_in raised mid-frame, held -> front_buf_out toggles only after nf_in; swap_ack_out single pulse; no second swap on following nf_in while req still high.
REQ-039 swap_req_in and nf_in asserted same cycle -> swap that cycle, ack next; req dropped before nf_in -> no swap, no ack.
REQ-040 rst_n_in pulsed low mid-line between clock edges -> all outputs 0 immediately; front_buf_out=0; pending swap lost.
